// File: rtl/wb_sequencer_pkg.sv
// Shared definitions for the write-back sequencer slice: mux select codes,
// drain FSM encoding, register-address width and the retirement select helper.
package wb_sequencer_pkg;

  localparam int RA_W     = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    WB_SEL_PC  = 2'd0,
    WB_SEL_ALU = 2'd1,
    WB_SEL_MEM = 2'd2,
    WB_SEL_IMM = 2'd3
  } wbSel_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } seqState_e;

  // A retirement can never legally pick the memory input; an illegal code
  // of 2 is folded onto the ALU path so the port still writes something sane.
  function automatic logic [1:0] retSel(input logic [1:0] src);
    logic [1:0] sel;
    sel = src;
    if (src == WB_SEL_MEM) sel = WB_SEL_ALU;
    return sel;
  endfunction

endpackage

// File: rtl/wb_sequencer_if.sv
// Bundle of the retirement, load, decode, write-port and drain signals that
// connect the sequencer to the rest of the pipeline.
interface wb_sequencer_if;
  import wb_sequencer_pkg::*;

  logic            ret_valid;
  logic [RA_W-1:0] ret_rd;
  logic [1:0]      ret_src;
  logic            ret_ready;

  logic            ld_issue_valid;
  logic [RA_W-1:0] ld_issue_rd;
  logic            ld_issue_ready;

  logic            mem_rsp_valid;
  logic [RA_W-1:0] mem_rsp_rd;

  logic            dec_valid;
  logic [RA_W-1:0] dec_rs1;
  logic [RA_W-1:0] dec_rs2;
  logic [RA_W-1:0] dec_rd;
  logic            hazard_stall;

  logic [1:0]      mux_sel;
  logic            rf_we;
  logic [RA_W-1:0] rf_waddr;

  logic            drain_req;
  logic            drain_done;
  logic            rsp_err;

  // Pipeline side: drives requests, observes grants and write-port controls.
  modport master (
    output ret_valid, ret_rd, ret_src,
    output ld_issue_valid, ld_issue_rd,
    output mem_rsp_valid, mem_rsp_rd,
    output dec_valid, dec_rs1, dec_rs2, dec_rd,
    output drain_req,
    input  ret_ready, ld_issue_ready, hazard_stall,
    input  mux_sel, rf_we, rf_waddr,
    input  drain_done, rsp_err
  );

  // Sequencer side.
  modport slave (
    input  ret_valid, ret_rd, ret_src,
    input  ld_issue_valid, ld_issue_rd,
    input  mem_rsp_valid, mem_rsp_rd,
    input  dec_valid, dec_rs1, dec_rs2, dec_rd,
    input  drain_req,
    output ret_ready, ld_issue_ready, hazard_stall,
    output mux_sel, rf_we, rf_waddr,
    output drain_done, rsp_err
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Per-register busy scoreboard for outstanding loads plus the outstanding
// load counter. All lookups read the registered busy vector, so an update
// made this cycle is only visible to lookups from the next cycle.
module wb_scoreboard
  import wb_sequencer_pkg::*;
#(
  parameter int MAX_LOADS = 4,
  parameter int CNT_W     = 4
) (
  input  logic            clk,
  input  logic            rst,
  // load issue accepted: mark rd busy and count it
  input  logic            setEn,
  input  logic [RA_W-1:0] setRd,
  // response to a busy register: release it
  input  logic            clrEn,
  input  logic [RA_W-1:0] clrRd,
  // response that retires an outstanding load
  input  logic            decEn,
  // lookups
  input  logic [RA_W-1:0] issueRd,
  input  logic [RA_W-1:0] rspRd,
  input  logic            decValid,
  input  logic [RA_W-1:0] decRs1,
  input  logic [RA_W-1:0] decRs2,
  input  logic [RA_W-1:0] decRd,
  output logic            issueRdBusy,
  output logic            rspRdBusy,
  output logic            countFull,
  output logic            countZero,
  output logic            hazard
);

  logic [NUM_REGS-1:0] busy;
  logic [CNT_W-1:0]    count;
  logic                doDec;

  // Never step below zero; a stray response must not wrap the counter.
  assign doDec = decEn && (count != '0);

  // Busy vector: clear on matching response, set on accepted issue (x0 never).
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clrEn) busy[clrRd] <= 1'b0;
      if (setEn && (setRd != '0)) busy[setRd] <= 1'b1;
    end
  end

  // Outstanding counter: simultaneous issue and retire cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case ({setEn, doDec})
        2'b10:   if (!countFull) count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign countFull   = (count >= CNT_W'(MAX_LOADS));
  assign countZero   = (count == '0);
  assign issueRdBusy = busy[issueRd];
  assign rspRdBusy   = busy[rspRd];

  // RAW on either source and WAW on the destination against pending loads.
  assign hazard = decValid && ((busy[decRs1] && (decRs1 != '0)) ||
                               (busy[decRs2] && (decRs2 != '0)) ||
                               (busy[decRd]  && (decRd  != '0)));

endmodule

// File: rtl/wb_sequencer.sv
// Write-back sequencer: arbitrates the single register-file write port
// between in-order retirements and out-of-order load responses, drives the
// clocked write-back mux select, aligns the write enable/address one cycle
// later to match the mux register, and runs the fence/trap drain handshake.
module wb_sequencer
  import wb_sequencer_pkg::*;
#(
  parameter int MAX_LOADS = 4,
  parameter int CNT_W     = 4
) (
  input  logic          clk,
  input  logic          rst,
  wb_sequencer_if.slave bus
);

  seqState_e       state;
  logic            drainDone;
  logic            rspErr;
  logic            rfWe;
  logic [RA_W-1:0] rfWaddr;
  logic [1:0]      selHold;
  logic [1:0]      muxSel;

  logic memGrant;
  logic retGrant;
  logic rspHit;
  logic rspStray;
  logic rspRetire;
  logic issueReady;
  logic issueAcc;

  logic issueRdBusy;
  logic rspRdBusy;
  logic countFull;
  logic countZero;
  logic hazard;

  wb_scoreboard #(
    .MAX_LOADS (MAX_LOADS),
    .CNT_W     (CNT_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .setEn       (issueAcc),
    .setRd       (bus.ld_issue_rd),
    .clrEn       (rspHit),
    .clrRd       (bus.mem_rsp_rd),
    .decEn       (rspRetire),
    .issueRd     (bus.ld_issue_rd),
    .rspRd       (bus.mem_rsp_rd),
    .decValid    (bus.dec_valid),
    .decRs1      (bus.dec_rs1),
    .decRs2      (bus.dec_rs2),
    .decRd       (bus.dec_rd),
    .issueRdBusy (issueRdBusy),
    .rspRdBusy   (rspRdBusy),
    .countFull   (countFull),
    .countZero   (countZero),
    .hazard      (hazard)
  );

  // Load responses cannot be back-pressured, so they always win the port.
  assign memGrant = bus.mem_rsp_valid;
  assign retGrant = bus.ret_valid && !bus.mem_rsp_valid;

  // Response classification against the registered busy vector.
  assign rspHit    = bus.mem_rsp_valid && rspRdBusy;
  assign rspStray  = bus.mem_rsp_valid && !rspRdBusy && (bus.mem_rsp_rd != '0);
  assign rspRetire = bus.mem_rsp_valid && (rspRdBusy || (bus.mem_rsp_rd == '0));

  // Issue readiness uses registered busy: a same-cycle release does not help.
  assign issueReady = (state == RUN) && !countFull && !issueRdBusy;
  assign issueAcc   = bus.ld_issue_valid && issueReady;

  // Select for the clocked mux; holds the previous choice when idle.
  always_comb begin
    muxSel = selHold;
    if (memGrant)      muxSel = WB_SEL_MEM;
    else if (retGrant) muxSel = retSel(bus.ret_src);
  end

  // Remember the last select so an idle cycle leaves the mux untouched.
  always_ff @(posedge clk) begin
    if (rst) selHold <= WB_SEL_PC;
    else     selHold <= muxSel;
  end

  // Write-port controls, one cycle behind the grant to line up with mux data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rfWe    <= 1'b0;
      rfWaddr <= '0;
    end else begin
      rfWe <= rspHit || (retGrant && (bus.ret_rd != '0));
      if (memGrant)      rfWaddr <= bus.mem_rsp_rd;
      else if (retGrant) rfWaddr <= bus.ret_rd;
    end
  end

  // Sticky flag for a response arriving for a register nobody is waiting on.
  always_ff @(posedge clk) begin
    if (rst)           rspErr <= 1'b0;
    else if (rspStray) rspErr <= 1'b1;
  end

  // Drain FSM: stop issuing, wait for the counter to empty, pulse done once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      drainDone <= 1'b0;
    end else begin
      drainDone <= 1'b0;
      unique case (state)
        RUN: begin
          if (bus.drain_req) begin
            if (countZero && !issueAcc) begin
              state     <= DONE;
              drainDone <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (countZero) begin
            state     <= DONE;
            drainDone <= 1'b1;
          end
        end
        DONE: begin
          if (!bus.drain_req) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.ret_ready      = retGrant;
  assign bus.ld_issue_ready = issueReady;
  assign bus.hazard_stall   = hazard;
  assign bus.mux_sel        = muxSel;
  assign bus.rf_we          = rfWe;
  assign bus.rf_waddr       = rfWaddr;
  assign bus.drain_done     = drainDone;
  assign bus.rsp_err        = rspErr;

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed bench for wb_sequencer: grant priority, write alignment, load
// scoreboard hazards, issue limits, drain handshake, stray responses, reset.
module tb_wb_sequencer;
  import wb_sequencer_pkg::*;

  logic clk;
  logic rst;
  int   nChecks;
  int   nFail;
  int   pulses;

  wb_sequencer_if bus ();

  wb_sequencer #(
    .MAX_LOADS (4),
    .CNT_W     (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Retirements must never carry the memory select code.
  always @(posedge clk) begin
    if (!rst && bus.ret_valid)
      assert (bus.ret_src != 2'd2) else $error("illegal ret_src=2 on retirement");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.ret_valid      = 1'b0;
    bus.ret_rd         = '0;
    bus.ret_src        = '0;
    bus.ld_issue_valid = 1'b0;
    bus.ld_issue_rd    = '0;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_rd     = '0;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.ld_issue_valid = 1'b1;
    bus.ld_issue_rd    = rd;
    settle();
    check($sformatf("issue_ready_rd%0d", rd), bus.ld_issue_ready, 1'b1);
    step();
    bus.ld_issue_valid = 1'b0;
  endtask

  task automatic respond(input logic [4:0] rd);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rd    = rd;
    settle();
    check($sformatf("rsp_sel_rd%0d", rd), bus.mux_sel, 2'd2);
    step();
    bus.mem_rsp_valid = 1'b0;
  endtask

  initial begin
    nChecks = 0;
    nFail   = 0;
    rst     = 1'b1;
    idle();
    bus.dec_valid = 1'b0;
    bus.dec_rs1   = '0;
    bus.dec_rs2   = '0;
    bus.dec_rd    = '0;
    bus.drain_req = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    settle();

    // Reset state
    check("rst_rf_we", bus.rf_we, 1'b0);
    check("rst_rf_waddr", bus.rf_waddr, 5'd0);
    check("rst_mux_sel", bus.mux_sel, 2'd0);
    check("rst_drain_done", bus.drain_done, 1'b0);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_issue_ready", bus.ld_issue_ready, 1'b1);

    // Retirement rd=5 from alu
    bus.ret_valid = 1'b1; bus.ret_rd = 5'd5; bus.ret_src = 2'd1;
    settle();
    check("ret_sel", bus.mux_sel, 2'd1);
    check("ret_ready", bus.ret_ready, 1'b1);
    check("ret_no_early_we", bus.rf_we, 1'b0);
    step();
    idle();
    check("ret_we", bus.rf_we, 1'b1);
    check("ret_waddr", bus.rf_waddr, 5'd5);
    settle();
    check("sel_hold", bus.mux_sel, 2'd1);
    check("ret_ready_idle", bus.ret_ready, 1'b0);
    step();
    check("we_one_cycle", bus.rf_we, 1'b0);

    // Retirement from imm, then to x0
    bus.ret_valid = 1'b1; bus.ret_rd = 5'd6; bus.ret_src = 2'd3;
    settle();
    check("imm_sel", bus.mux_sel, 2'd3);
    step();
    check("imm_waddr", bus.rf_waddr, 5'd6);
    bus.ret_rd = 5'd0; bus.ret_src = 2'd0;
    settle();
    check("x0_ready", bus.ret_ready, 1'b1);
    check("pc_sel", bus.mux_sel, 2'd0);
    step();
    idle();
    check("x0_no_we", bus.rf_we, 1'b0);

    // Load rd=7 then decode reads it in rs2
    bus.dec_valid = 1'b1; bus.dec_rs2 = 5'd7;
    bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd7;
    settle();
    check("ld7_ready", bus.ld_issue_ready, 1'b1);
    check("haz_same_cycle", bus.hazard_stall, 1'b0);
    step();
    settle();
    check("haz_rs2", bus.hazard_stall, 1'b1);
    check("ld7_busy_reject", bus.ld_issue_ready, 1'b0);
    bus.ld_issue_valid = 1'b0;
    bus.dec_rs2 = 5'd0; bus.dec_rd = 5'd7;
    settle();
    check("haz_waw", bus.hazard_stall, 1'b1);
    bus.dec_rd = 5'd0; bus.dec_rs2 = 5'd7;
    respond(5'd7);
    check("rsp7_we", bus.rf_we, 1'b1);
    check("rsp7_waddr", bus.rf_waddr, 5'd7);
    settle();
    check("haz_clear", bus.hazard_stall, 1'b0);
    bus.dec_valid = 1'b0; bus.dec_rs2 = 5'd0;

    // Response rd3 and retirement rd4 in the same cycle
    issue(5'd3);
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rd = 5'd3;
    bus.ret_valid = 1'b1; bus.ret_rd = 5'd4; bus.ret_src = 2'd1;
    settle();
    check("coll_sel_mem", bus.mux_sel, 2'd2);
    check("coll_ret_blocked", bus.ret_ready, 1'b0);
    step();
    bus.mem_rsp_valid = 1'b0;
    check("coll_we1", bus.rf_we, 1'b1);
    check("coll_waddr1", bus.rf_waddr, 5'd3);
    settle();
    check("coll_ret_ready", bus.ret_ready, 1'b1);
    check("coll_sel_alu", bus.mux_sel, 2'd1);
    step();
    idle();
    check("coll_we2", bus.rf_we, 1'b1);
    check("coll_waddr2", bus.rf_waddr, 5'd4);

    // Fill to four outstanding loads
    for (int r = 1; r <= 4; r++) issue(5'(r));
    bus.ld_issue_rd = 5'd5;
    settle();
    check("full_reject", bus.ld_issue_ready, 1'b0);
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rd = 5'd1;
    settle();
    check("full_same_cycle", bus.ld_issue_ready, 1'b0);
    step();
    bus.mem_rsp_valid = 1'b0;
    settle();
    check("slot_free_ready", bus.ld_issue_ready, 1'b1);
    bus.ld_issue_rd = 5'd2;
    settle();
    check("busy2_reject", bus.ld_issue_ready, 1'b0);
    // Release of rd2 in the same cycle still rejects the issue to rd2
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rd = 5'd2;
    bus.ld_issue_valid = 1'b1;
    settle();
    check("same_rd_reject", bus.ld_issue_ready, 1'b0);
    step();
    idle();
    // Outstanding now: rd3, rd4

    // Drain with two loads pending
    bus.drain_req = 1'b1;
    step();
    bus.ld_issue_rd = 5'd9;
    settle();
    check("drain_issue_block", bus.ld_issue_ready, 1'b0);
    check("drain_not_done", bus.drain_done, 1'b0);
    pulses = 0;
    respond(5'd3);
    if (bus.drain_done) pulses++;
    respond(5'd4);
    if (bus.drain_done) pulses++;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.drain_done) pulses++;
    end
    check("drain_pulses", pulses, 1);
    check("done_issue_block", bus.ld_issue_ready, 1'b0);
    bus.drain_req = 1'b0;
    step();
    step();
    settle();
    check("run_again_ready", bus.ld_issue_ready, 1'b1);

    // Stray response to rd9
    respond(5'd9);
    check("stray_err", bus.rsp_err, 1'b1);
    check("stray_no_we", bus.rf_we, 1'b0);
    step();
    check("err_sticky", bus.rsp_err, 1'b1);

    // Reset with three loads pending
    issue(5'd10);
    issue(5'd11);
    issue(5'd12);
    bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd10;
    settle();
    check("pre_rst_hazard", bus.hazard_stall, 1'b1);
    bus.ret_valid = 1'b1; bus.ret_rd = 5'd8; bus.ret_src = 2'd1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    settle();
    check("post_rst_we", bus.rf_we, 1'b0);
    check("post_rst_hazard", bus.hazard_stall, 1'b0);
    check("post_rst_err", bus.rsp_err, 1'b0);
    bus.ld_issue_rd = 5'd10;
    settle();
    check("post_rst_ready", bus.ld_issue_ready, 1'b1);
    bus.dec_valid = 1'b0; bus.dec_rs1 = 5'd0;

    // Drain with nothing outstanding finishes after one cycle
    bus.drain_req = 1'b1;
    step();
    check("empty_drain_done", bus.drain_done, 1'b1);
    step();
    check("done_hold_low", bus.drain_done, 1'b0);
    bus.drain_req = 1'b0;
    step();
    settle();
    check("empty_drain_run", bus.ld_issue_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
